img_to_axi4s_buffered: RTL
==========================

Name: img_to_axi4s_buffered

Overview:
- Synthesizable bridge from the img bus (row/col first/last, de, data, valid) to AXI4-Stream video (tuser = frame start, tlast = end of line).
- It is the producer-side counterpart to the axi4s-to-img path that feeds image processing.
- The img bus has no backpressure, so pixels are absorbed into an internal FIFO.
- It tracks frame synchronisation and detects overflow; output is suitable for a VDMA writer.

Parameters:
- COMPONENTS, 1, number of components per pixel.
- DATA_WIDTH, 10, bits per component.
- FIFO_PTR_WIDTH, 6, FIFO depth = 2**FIFO_PTR_WIDTH entries.
- CNT_WIDTH, 16, width of the dropped-frame counter.

Ports:
- reset  input  1  Asynchronous, active-high reset.
- clk  input  1  Single clock for both img and AXI4-Stream sides.
- cke  input  1  img-side clock enable; gates input sampling only.
- s_img_row_first  input  1  First line of frame.
- s_img_row_last  input  1  Last line of frame.
- s_img_col_first  input  1  First pixel of line.
- s_img_col_last  input  1  Last pixel of line.
- s_img_de  input  1  Data enable (active pixel).
- s_img_data  input  COMPONENTS*DATA_WIDTH  Pixel data.
- s_img_valid  input  1  Bus valid.
- m_axi4s_tuser  output  1  Frame start.
- m_axi4s_tlast  output  1  End of line.
- m_axi4s_tdata  output  COMPONENTS*DATA_WIDTH  Pixel data.
- m_axi4s_tvalid  output  1  Output valid.
- m_axi4s_tready  input  1  Output ready.
- overflow  output  1  Sticky flag: a pixel was lost.
- overflow_clear  input  1  Synchronous clear for overflow.
- drop_count  output  CNT_WIDTH  Frames discarded, wrapping at 2**CNT_WIDTH.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state WAIT_FRAME. tvalid, tuser, tlast, overflow = 0; tdata = 0; drop_count = 0.
- Input pixel event: cke & s_img_valid & s_img_de at a rising edge.
- Entry format: {tuser = row_first & col_first, tlast = col_last, data}.
- State machine (state updates only when cke = 1):
  - WAIT_FRAME: discard all pixels. A pixel event with row_first & col_first writes the entry and moves to PASS.
  - PASS: every pixel event writes an entry. If the FIFO is full, the pixel is discarded and overflow is set; state handling follows the Optional Feature.
  - DROP: discard pixels. A pixel event with row_first & col_first increments drop_count, writes the entry (if not full) and returns to PASS. If full, it stays in DROP and overflow is set.
- Full test: full is evaluated on pre-edge occupancy. A write on a full FIFO is dropped even if a read occurs in the same cycle.
- Read side: the output register loads when (!tvalid | tready) and the FIFO is non-empty.
- Latency: a pixel written at edge N drives tvalid = 1 after edge N+1 if the output register is free.
- Output hold: the tdata/tuser/tlast hold stable while tvalid & !tready.
- Throughput: 1 pixel/clk with tready held at 1.
- cke = 0: the output side continues draining. No writes occur and the state is frozen.
- overflow clear vs. set: overflow_clear clears overflow. A set in the same cycle wins.
- Counter wrap: drop_count wraps from all-ones to 0.
- Mid-frame reset: all data is lost. After release the block waits for the next frame start and never emits a partial frame.

Optional Feature:
- Macro: IMG_TO_AXI4S_FRAME_DROP_EN.
- Defined: overflow in PASS moves the state to DROP. The rest of the frame is discarded; pixels already queued still drain. drop_count counts each resynchronisation.
- Undefined: the DROP state is not built. Only the overflowing pixel is lost, the state remains PASS, and drop_count is tied to 0.

Test Plan:
- Frame passthrough: send a 16x4 frame with tready = 1 and cke = 1 → 64 beats.
  - tuser only on beat 0; tlast on beats 15, 31, 47, 63.
  - Data matches input; first tvalid 1 clk after the first write.
- Mid-frame start: release reset at line 2 of a frame → no output until the next frame's row_first & col_first pixel. Then exactly 64 beats with tuser on the first.
- Backpressure: FIFO_PTR_WIDTH = 4, tready = 0 for 20 clks during continuous input.
  - overflow = 1 after the 17th pending pixel.
  - With the macro defined: the remaining pixels of the frame are absent, the next frame is intact, and drop_count = 1.
  - Without the macro: only the overflowed pixels are missing and drop_count = 0.
- Stall hold: toggle tready randomly at 50% → tdata/tuser/tlast are unchanged while tvalid & !tready. No beat is lost or duplicated.
- cke gating: hold cke = 0 for 8 clks while s_img_valid & s_img_de = 1 → none of those pixels appear. Queued data still drains.
- Clear priority: assert overflow_clear in the same cycle as a new overflow → overflow stays 1. Clear alone → 0 next clk.

Source files
------------

// File: rtl/img_to_axi4s_buffered.sv
`default_nettype none
// ============================================================================
// Module   : img_to_axi4s_buffered
// Brief    : img bus to AXI4-Stream video bridge with input FIFO, frame sync
//            and sticky overflow. Define IMG_TO_AXI4S_FRAME_DROP_EN to discard
//            the remainder of a frame after an overflow and count resyncs.
// Revision : 1.0
// ============================================================================
module img_to_axi4s_buffered #(
  parameter int COMPONENTS     = 1,
  parameter int DATA_WIDTH     = 10,
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             reset,
  input  logic                             clk,
  input  logic                             cke,
  input  logic                             s_img_row_first,
  input  logic                             s_img_row_last,
  input  logic                             s_img_col_first,
  input  logic                             s_img_col_last,
  input  logic                             s_img_de,
  input  logic [COMPONENTS*DATA_WIDTH-1:0] s_img_data,
  input  logic                             s_img_valid,
  output logic                             m_axi4s_tuser,
  output logic                             m_axi4s_tlast,
  output logic [COMPONENTS*DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                             m_axi4s_tvalid,
  input  logic                             m_axi4s_tready,
  output logic                             overflow,
  input  logic                             overflow_clear,
  output logic [CNT_WIDTH-1:0]             drop_count
);

  localparam int TW    = COMPONENTS * DATA_WIDTH;
  localparam int EW    = TW + 2;
  localparam int PW    = FIFO_PTR_WIDTH;
  localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_PASS       = 2'd1,
    ST_DROP       = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic              tvalid_q, tvalid_d;
  logic              tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic [TW-1:0]     tdata_q, tdata_d;
  logic              overflow_q, overflow_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pix_evt;
  logic              pix_sof;
  logic              wr_en;
  logic              rd_en;
  logic              out_free;
  logic              ovf_set;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;
  logic              unused_row_last;

  assign unused_row_last = s_img_row_last;

  assign pix_evt  = cke & s_img_valid & s_img_de;
  assign pix_sof  = s_img_row_first & s_img_col_first;
  assign wr_entry = {pix_sof, s_img_col_last, s_img_data};

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rd_entry   = mem_q[rd_ptr_q[PW-1:0]];

`ifdef IMG_TO_AXI4S_FRAME_DROP_EN
  logic                 drop_inc;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
`endif

  // Frame-sync state machine; it only moves on a pixel event, so cke = 0 freezes it.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    ovf_set = 1'b0;
`ifdef IMG_TO_AXI4S_FRAME_DROP_EN
    drop_inc = 1'b0;
`endif
    case (state_q)
      ST_WAIT_FRAME: begin
        if (pix_evt && pix_sof) begin
          if (fifo_full) ovf_set = 1'b1;
          else           wr_en   = 1'b1;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (pix_evt) begin
          if (!fifo_full) begin
            wr_en = 1'b1;
          end else begin
            ovf_set = 1'b1;
`ifdef IMG_TO_AXI4S_FRAME_DROP_EN
            state_d = ST_DROP;
`endif
          end
        end
      end
`ifdef IMG_TO_AXI4S_FRAME_DROP_EN
      ST_DROP: begin
        if (pix_evt && pix_sof) begin
          if (!fifo_full) begin
            wr_en    = 1'b1;
            drop_inc = 1'b1;
            state_d  = ST_PASS;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_WAIT_FRAME;
    endcase
  end

  always_comb begin
    out_free = !tvalid_q || m_axi4s_tready;
    rd_en    = out_free && !fifo_empty;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    if (rd_en) begin
      tvalid_d                    = 1'b1;
      {tuser_d, tlast_d, tdata_d} = rd_entry;
    end else if (out_free) begin
      tvalid_d = 1'b0;
    end
    wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, wr_en};
    rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, rd_en};
    // A new overflow beats a simultaneous clear.
    overflow_d = ovf_set ? 1'b1 : (overflow_clear ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[PW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT_FRAME;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tvalid_q   <= tvalid_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef IMG_TO_AXI4S_FRAME_DROP_EN
  always_comb begin
    drop_count_d = drop_count_q + {{(CNT_WIDTH-1){1'b0}}, drop_inc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_count_q <= '0;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

  assign m_axi4s_tvalid = tvalid_q;
  assign m_axi4s_tuser  = tuser_q;
  assign m_axi4s_tlast  = tlast_q;
  assign m_axi4s_tdata  = tdata_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire
